// File: rtl/serial_stream_feeder.sv
// rtl/serial_stream_feeder.sv - MSB-first parallel-to-serial feeder with one-word holding buffer
module serial_stream_feeder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] Data,
  input  logic             Load,
  output logic             Ready,
  output logic             SerOut,
  output logic             Valid,
  output logic             Done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   shift_reg, shift_nxt;
  logic [WIDTH-1:0]   hold_reg, hold_nxt;
  logic               hold_full, hold_full_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               last_bit;
  logic               accept;

  assign last_bit = (state == SHIFT) && (count == CNT_W'(WIDTH - 1));
  assign Ready    = ~hold_full | last_bit;
  assign accept   = Load & Ready;
  assign Valid    = (state == SHIFT);
  assign SerOut   = (state == SHIFT) & shift_reg[WIDTH-1];
  assign Done     = last_bit;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      count     <= '0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      hold_reg  <= hold_nxt;
      hold_full <= hold_full_nxt;
      count     <= count_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shift_nxt     = shift_reg;
    hold_nxt      = hold_reg;
    hold_full_nxt = hold_full;
    count_nxt     = count;
    case (state)
      IDLE: begin
        if (accept) begin
          shift_nxt = Data;
          count_nxt = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          if (hold_full) begin
            // Held word takes over with no gap; a same-edge load refills the buffer.
            shift_nxt = hold_reg;
            count_nxt = '0;
            if (accept) hold_nxt = Data;
            else        hold_full_nxt = 1'b0;
          end else if (accept) begin
            shift_nxt = Data;
            count_nxt = '0;
          end else begin
            state_nxt = IDLE;
            shift_nxt = '0;
            count_nxt = '0;
          end
        end else begin
          shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
          count_nxt = count + CNT_W'(1);
          if (accept) begin
            hold_nxt      = Data;
            hold_full_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_stream_feeder.sv
// tb/tb_serial_stream_feeder.sv - scoreboard bench for serial_stream_feeder
module tb_serial_stream_feeder;

  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic [WIDTH-1:0] Data = '0;
  logic             Load = 1'b0;
  logic             Ready, SerOut, Valid, Done;

  int n_vec = 0;
  int n_err = 0;

  // Each entry is {bit, done} for one future SerOut cycle; front is the bit now on the wire.
  logic [1:0] sb[$];

  serial_stream_feeder #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Data   (Data),
    .Load   (Load),
    .Ready  (Ready),
    .SerOut (SerOut),
    .Valid  (Valid),
    .Done   (Done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_ready();
    return (sb.size() <= WIDTH + 1);
  endfunction

  task automatic check_outputs();
    logic [1:0] e;
    e = (sb.size() > 0) ? sb[0] : 2'b00;
    check("valid",  {31'd0, Valid},  {31'd0, sb.size() > 0});
    check("serout", {31'd0, SerOut}, {31'd0, e[1]});
    check("done",   {31'd0, Done},   {31'd0, e[0]});
    check("ready",  {31'd0, Ready},  {31'd0, model_ready()});
  endtask

  // Called at a negedge: check, drive, advance one clock, return at next negedge.
  task automatic step(input logic ld, input logic [WIDTH-1:0] d);
    logic acc;
    check_outputs();
    Load = ld;
    Data = d;
    acc  = ld && model_ready();
    @(posedge CLK);
    if (sb.size() > 0) void'(sb.pop_front());
    if (acc)
      for (int i = WIDTH - 1; i >= 0; i--) sb.push_back({d[i], i == 0});
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 255));
  endtask

  initial begin
    @(negedge CLK);
    check_outputs();
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);

    // Single word, CC
    step(1'b1, 8'hCC);
    idle(10);

    // Back-to-back 03 then 00
    step(1'b1, 8'h03);
    idle(2);
    step(1'b1, 8'h00);
    idle(20);

    // Third load held while buffer is full: accepted only on the last bit
    step(1'b1, 8'h55);
    step(1'b1, 8'h0F);
    for (int i = 0; i < 10; i++) step(1'b1, 8'hAA);
    idle(30);

    // Reset mid-word with a word held
    step(1'b1, 8'hF0);
    step(1'b1, 8'h33);
    step(1'b0, 8'h00);
    check_outputs();
    #2 RST = 1'b0;
    #1;
    sb.delete();
    check("rst_valid",  {31'd0, Valid},  32'd0);
    check("rst_serout", {31'd0, SerOut}, 32'd0);
    check("rst_done",   {31'd0, Done},   32'd0);
    check("rst_ready",  {31'd0, Ready},  32'd1);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    step(1'b1, 8'h0C);
    idle(12);

    // Idle gap then restart
    step(1'b1, 8'hC0);
    idle(15);
    step(1'b1, 8'hC0);
    idle(12);

    // Random load/data mix
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 3) == 0), $urandom_range(0, 255));
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
